dram_arbiter: RTL

Two-requester arbiter and protocol sequencer placed in front of the pseudo-DRAM AXI-style port. It accepts single-beat read/write requests from two clients and grants them round-robin. It then drives the AR/R or AW/W/B channel sequence for one transaction at a time and returns read data or write completion to the granted client. All DRAM-side protocol rules (zeroed idle buses, stable address/valid, no early data/ready) are enforced here, so clients never touch the DRAM channels.

---
 rtl/dram_arb_pkg.sv | 26 ++
 rtl/dram_arbiter_if.sv | 56 +++++
 rtl/dram_arbiter_rr_arb2.sv | 32 +++
 rtl/dram_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-client DRAM arbiter.
package dram_arb_pkg;

  localparam int N_REQ      = 2;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 64;
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_e;

  // Client word address zero-extended onto the 32-bit DRAM address bus.
  function automatic logic [AXI_ADDR_W-1:0] axi_addr(input logic [ADDR_W-1:0] a);
    return {{(AXI_ADDR_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Client request/completion bus plus the DRAM AR/R/AW/W/B channels.
interface dram_arbiter_if;
  import dram_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;

  logic                    done_valid;
  logic                    done_id;
  logic [DATA_W-1:0]       done_data;
  logic                    done_err;

  logic                    AR_VALID;
  logic [AXI_ADDR_W-1:0]   AR_ADDR;
  logic                    AR_READY;
  logic                    R_VALID;
  logic [DATA_W-1:0]       R_DATA;
  logic [1:0]              R_RESP;
  logic                    R_READY;

  logic                    AW_VALID;
  logic [AXI_ADDR_W-1:0]   AW_ADDR;
  logic                    AW_READY;
  logic                    W_VALID;
  logic [DATA_W-1:0]       W_DATA;
  logic                    W_READY;
  logic                    B_VALID;
  logic [1:0]              B_RESP;
  logic                    B_READY;

  // The arbiter side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output done_valid, done_id, done_data, done_err,
    output AR_VALID, AR_ADDR, R_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP,
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP
  );

  // Clients plus the DRAM model.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  done_valid, done_id, done_data, done_err,
    input  AR_VALID, AR_ADDR, R_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP,
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AW_READY, W_READY, B_VALID, B_RESP
  );

endinterface

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-way round-robin grant; on contention the client not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  logic last_q, last_d;

  always_comb begin
    last_d     = upd_i ? upd_id_i : last_q;
    grant_id_o = (req_i == 2'b11) ? ~last_q : req_i[1];
    grant_o    = 2'b00;
    if (req_i != 2'b00) begin
      grant_o = grant_id_o ? 2'b10 : 2'b01;
    end
  end

  // Pointer starts at 1 so client 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter and single-outstanding AR/R or AW/W/B sequencer in front of the DRAM port.
module dram_arbiter
  import dram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dram_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic                id_q, id_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                  ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic                  r_ready_q, r_ready_d;
  logic                  aw_valid_q, aw_valid_d;
  logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic                  w_valid_q, w_valid_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic                  b_ready_q, b_ready_d;
  logic                  done_valid_q, done_valid_d;
  logic                  done_id_q, done_id_d;
  logic [DATA_W-1:0]     done_data_q, done_data_d;
  logic                  done_err_q, done_err_d;

  logic [N_REQ-1:0]  grant;
  logic              grant_id;
  logic              accept;
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req_valid),
    .upd_i     (state_q == S_DONE),
    .upd_id_i  (id_q),
    .grant_o   (grant),
    .grant_id_o(grant_id)
  );

  assign bus.req_ready = (state_q == S_IDLE) ? grant : '0;
  assign accept        = (state_q == S_IDLE) && (grant != '0);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d    = grant_id;
          wr_d    = bus.req_write[grant_id];
          addr_d  = addr_arr[grant_id];
          wdata_d = wdata_arr[grant_id];
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = bus.req_write[grant_id] ? S_AW : S_AR;
        end
      end
      S_AR: if (bus.AR_READY) state_d = S_R;
      S_R: begin
        if (bus.R_VALID) begin
          rdata_d = bus.R_DATA;
          err_d   = (bus.R_RESP != RESP_OKAY);
          state_d = S_DONE;
        end
      end
      S_AW: if (bus.AW_READY) state_d = S_W;
      S_W:  if (bus.W_READY) state_d = S_B;
      S_B: begin
        if (bus.B_VALID) begin
          err_d   = (bus.B_RESP != RESP_OKAY);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that they leave a register.
    ar_valid_d   = (state_d == S_AR);
    ar_addr_d    = ar_valid_d ? axi_addr(addr_d) : '0;
    r_ready_d    = (state_d == S_R);
    aw_valid_d   = (state_d == S_AW);
    aw_addr_d    = aw_valid_d ? axi_addr(addr_d) : '0;
    w_valid_d    = (state_d == S_W);
    w_data_d     = w_valid_d ? wdata_d : '0;
    b_ready_d    = (state_d == S_B);
    done_valid_d = (state_d == S_DONE);
    done_id_d    = done_valid_d ? id_d : 1'b0;
    done_data_d  = (done_valid_d && !wr_d) ? rdata_d : '0;
    done_err_d   = done_valid_d ? err_d : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      b_ready_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      done_data_q  <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ar_valid_q   <= ar_valid_d;
      ar_addr_q    <= ar_addr_d;
      r_ready_q    <= r_ready_d;
      aw_valid_q   <= aw_valid_d;
      aw_addr_q    <= aw_addr_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      b_ready_q    <= b_ready_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_data_q  <= done_data_d;
      done_err_q   <= done_err_d;
    end
  end

  assign bus.AR_VALID   = ar_valid_q;
  assign bus.AR_ADDR    = ar_addr_q;
  assign bus.R_READY    = r_ready_q;
  assign bus.AW_VALID   = aw_valid_q;
  assign bus.AW_ADDR    = aw_addr_q;
  assign bus.W_VALID    = w_valid_q;
  assign bus.W_DATA     = w_data_q;
  assign bus.B_READY    = b_ready_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_data  = done_data_q;
  assign bus.done_err   = done_err_q;

endmodule
